vga_pattern_client: RTL and testbench

- Parametrised, pipelined successor to the team's combinational VGA colour client.
- Sits between the VGA timing generator (CurrentX/CurrentY/VBlank/HBlank) and the DAC pins. It computes a per-pixel colour from a frame-latched mode.
- Adds a registered two-stage pipeline, frame-synchronous mode switching, a frame counter, scrolling colour bars and a bouncing box whose state updates once per frame.

---
 rtl/vga_client_pkg.sv | 43 ++++
 rtl/vga_box_mover.sv | 65 ++++++
 rtl/vga_pattern_client.sv | 158 +++++++++++++++
 tb/tb_vga_pattern_client.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_client_pkg.sv
// vga_client_pkg
// Shared constants and helpers for the VGA pattern client.
//   MODE_*   : values of the frame-latched display mode
//   palette(): 8-entry colour table; channels are packed at PAL_MAX_CW bits
//              each so that one function serves any channel width up to 8.
package vga_client_pkg;

    localparam logic [2:0] MODE_BORDER  = 3'd0;
    localparam logic [2:0] MODE_PRODUCT = 3'd1;
    localparam logic [2:0] MODE_OVERLAY = 3'd2;
    localparam logic [2:0] MODE_BOX     = 3'd3;
    localparam logic [2:0] MODE_BARS    = 3'd4;

    localparam int PAL_MAX_CW = 8;

    // Returns {R,G,B}, each PAL_MAX_CW wide; only the low cw bits of each
    // channel are meaningful. F = all ones, H = half scale minus one.
    function automatic logic [3*PAL_MAX_CW-1:0] palette(input logic [2:0] idx,
                                                        input int         cw);
        logic [PAL_MAX_CW-1:0] f;
        logic [PAL_MAX_CW-1:0] h;
        logic [PAL_MAX_CW-1:0] r;
        logic [PAL_MAX_CW-1:0] g;
        logic [PAL_MAX_CW-1:0] b;
        f = PAL_MAX_CW'((1 << cw) - 1);
        h = PAL_MAX_CW'((1 << (cw - 1)) - 1);
        r = '0;
        g = '0;
        b = '0;
        case (idx)
            3'd0: begin r = '0; g = '0; b = '0; end
            3'd1: begin r = '0; g = '0; b = f;  end
            3'd2: begin r = '0; g = f;  b = '0; end
            3'd3: begin r = '0; g = f;  b = f;  end
            3'd4: begin r = f;  g = '0; b = '0; end
            3'd5: begin r = f;  g = '0; b = f;  end
            3'd6: begin r = f;  g = f;  b = '0; end
            default: begin r = h; g = h; b = h; end
        endcase
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// vga_box_mover
// Position of the bouncing box. Moves one step per enabled cycle (one frame
// tick) and reflects off the active-area edges.
//   CLK_100MHz : clock
//   RESET      : synchronous active-high reset, box returns to (BORDER,BORDER)
//   step_en    : advance one step this cycle
//   box_x/y    : top-left corner of the box
module vga_box_mover
    import vga_client_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int BORDER   = 100,
    parameter int BOX_SIZE = 64,
    parameter int SPEED    = 4,
    parameter int XW       = 11
) (
    input  logic          CLK_100MHz,
    input  logic          RESET,
    input  logic          step_en,
    output logic [XW-1:0] box_x,
    output logic [XW-1:0] box_y
);

    // One extra bit so pos + SPEED + BOX_SIZE cannot wrap.
    localparam int AW = XW + 1;

    // 0 = increasing, 1 = decreasing
    logic dir_x;
    logic dir_y;

    // Returns {new_dir, new_pos}.
    function automatic logic [XW:0] axis_step(input logic [XW-1:0] pos,
                                              input logic          dir,
                                              input logic [AW-1:0] limit);
        logic [AW-1:0] p;
        logic [AW-1:0] nxt;
        p   = {1'b0, pos};
        nxt = p + AW'(SPEED);
        if (!dir) begin
            if (nxt + AW'(BOX_SIZE) > limit)
                return {1'b1, XW'(limit - AW'(BOX_SIZE))};
            else
                return {1'b0, nxt[XW-1:0]};
        end else begin
            if (p < AW'(SPEED))
                return {1'b0, {XW{1'b0}}};
            else
                return {1'b1, XW'(p - AW'(SPEED))};
        end
    endfunction

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            box_x <= XW'(BORDER);
            box_y <= XW'(BORDER);
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (step_en) begin
            {dir_x, box_x} <= axis_step(box_x, dir_x, AW'(H_ACTIVE));
            {dir_y, box_y} <= axis_step(box_y, dir_y, AW'(V_ACTIVE));
        end
    end

endmodule

// File: rtl/vga_pattern_client.sv
// vga_pattern_client
// Per-pixel colour generator between the VGA timing generator and the DAC.
// Two register stages from CurrentX/CurrentY to RED/GREEN/BLUE in every mode;
// the blank flag travels alongside and forces black at the output.
// Mode and solid colour are latched only on the VBlank rising edge, so a
// frame is always drawn in a single mode.
//   CLK_100MHz          : clock
//   RESET               : synchronous active-high reset
//   CurrentX/CurrentY   : pixel coordinate
//   VBlank/HBlank       : blanking from the timing generator
//   MODE/COLOR_SEL      : requested mode / solid colour, taken at frame tick
//   wRed/wGreen/wBlue   : external overlay pixel, valid when yes = 1
//   RED/GREEN/BLUE      : registered colour outputs
//   FrameCount          : frames since reset, wraps at 256
module vga_pattern_client
    import vga_client_pkg::*;
#(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int BORDER    = 100,
    parameter int CW        = 4,
    parameter int XW        = 11,
    parameter int BOX_SIZE  = 64,
    parameter int SPEED     = 4,
    parameter int BAR_SHIFT = 7
) (
    input  logic          CLK_100MHz,
    input  logic          RESET,
    input  logic [XW-1:0] CurrentX,
    input  logic [XW-1:0] CurrentY,
    input  logic          VBlank,
    input  logic          HBlank,
    input  logic [2:0]    MODE,
    input  logic [2:0]    COLOR_SEL,
    input  logic [CW-1:0] wRed,
    input  logic [CW-1:0] wGreen,
    input  logic [CW-1:0] wBlue,
    input  logic          yes,
    output logic [CW-1:0] RED,
    output logic [CW-1:0] GREEN,
    output logic [CW-1:0] BLUE,
    output logic [7:0]    FrameCount
);

    localparam int AW = XW + 1;
    localparam logic [CW-1:0] GREY = CW'((1 << (CW - 1)) - 1);

    function automatic logic [3*CW-1:0] pal_rgb(input logic [2:0] idx);
        logic [3*PAL_MAX_CW-1:0] p;
        p = palette(idx, CW);
        return {p[2*PAL_MAX_CW +: CW], p[PAL_MAX_CW +: CW], p[0 +: CW]};
    endfunction

    // Frame tick and latched frame state
    logic          vblank_q;
    logic          frame_tick;
    logic [2:0]    mode_q;
    logic [2:0]    color_q;
    logic [XW-1:0] box_x;
    logic [XW-1:0] box_y;

    assign frame_tick = VBlank & ~vblank_q;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BORDER   (BORDER),
        .BOX_SIZE (BOX_SIZE),
        .SPEED    (SPEED),
        .XW       (XW)
    ) u_box (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (RESET),
        .step_en    (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // Stage-1 combinational colour
    logic [2*XW-1:0] prod;
    logic [AW-1:0]   bar_sum;
    logic [2:0]      bar_idx;
    logic            in_border;
    logic            in_box;
    logic [3*CW-1:0] colour_d;

    assign prod    = {{XW{1'b0}}, CurrentX} * {{XW{1'b0}}, CurrentY};
    assign bar_sum = {1'b0, CurrentX} + AW'(FrameCount);
    assign bar_idx = bar_sum[BAR_SHIFT +: 3];

    assign in_border = (CurrentX <  XW'(BORDER))            ||
                       (CurrentX >= XW'(H_ACTIVE - BORDER)) ||
                       (CurrentY <  XW'(BORDER))            ||
                       (CurrentY >= XW'(V_ACTIVE - BORDER));

    assign in_box = ({1'b0, CurrentX} >= {1'b0, box_x}) &&
                    ({1'b0, CurrentX} <  {1'b0, box_x} + AW'(BOX_SIZE)) &&
                    ({1'b0, CurrentY} >= {1'b0, box_y}) &&
                    ({1'b0, CurrentY} <  {1'b0, box_y} + AW'(BOX_SIZE));

    always_comb begin
        colour_d = '0;
        case (mode_q)
            MODE_PRODUCT: colour_d = '0;  // taken from the product register instead
            MODE_OVERLAY: colour_d = yes ? {wRed, wGreen, wBlue} : {3{GREY}};
            MODE_BOX:     colour_d = in_box ? pal_rgb(FrameCount[7:5]) : '0;
            MODE_BARS:    colour_d = pal_rgb(bar_idx);
            default:      colour_d = in_border ? '1 : pal_rgb(color_q);
        endcase
    end

    // Stage-1 registers
    logic            s1_blank;
    logic            s1_is_prod;
    logic [3*CW-1:0] s1_color;
    logic [2*XW-1:0] s1_prod;

    // Bits of wide intermediates that no mode looks at.
    logic unused_bits;
    assign unused_bits = ^{s1_prod[2*XW-1:3*CW+4], s1_prod[3:0],
                           bar_sum[AW-1:BAR_SHIFT+3], bar_sum[BAR_SHIFT-1:0]};

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            vblank_q   <= 1'b0;
            FrameCount <= '0;
            mode_q     <= MODE_BORDER;
            color_q    <= '0;
            s1_blank   <= 1'b1;
            s1_is_prod <= 1'b0;
            s1_color   <= '0;
            s1_prod    <= '0;
            RED        <= '0;
            GREEN      <= '0;
            BLUE       <= '0;
        end else begin
            vblank_q <= VBlank;
            if (frame_tick) begin
                FrameCount <= FrameCount + 8'd1;
                mode_q     <= MODE;
                color_q    <= COLOR_SEL;
            end

            s1_blank   <= VBlank | HBlank;
            s1_is_prod <= (mode_q == MODE_PRODUCT);
            s1_color   <= colour_d;
            s1_prod    <= prod;

            if (s1_blank)
                {RED, GREEN, BLUE} <= '0;
            else if (s1_is_prod)
                {RED, GREEN, BLUE} <= s1_prod[3*CW+3:4];
            else
                {RED, GREEN, BLUE} <= s1_color;
        end
    end

endmodule

// File: tb/tb_vga_pattern_client.sv
// Testbench for vga_pattern_client (default parameters: 800x600, CW=4).
// Every drive() call is one clock: it compares the output for the pixel
// driven two cycles earlier against the expected queue, then applies new
// inputs and pushes their expected colour, computed from a frame-level model.
module tb_vga_pattern_client;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET     = 1'b1;
    logic [10:0] CurrentX  = '0;
    logic [10:0] CurrentY  = '0;
    logic        VBlank    = 1'b0;
    logic        HBlank    = 1'b1;
    logic [2:0]  MODE      = '0;
    logic [2:0]  COLOR_SEL = '0;
    logic [3:0]  wRed      = '0;
    logic [3:0]  wGreen    = '0;
    logic [3:0]  wBlue     = '0;
    logic        yes       = 1'b0;
    logic [3:0]  RED;
    logic [3:0]  GREEN;
    logic [3:0]  BLUE;
    logic [7:0]  FrameCount;

    vga_pattern_client dut (
        .CLK_100MHz (clk),
        .RESET      (RESET),
        .CurrentX   (CurrentX),
        .CurrentY   (CurrentY),
        .VBlank     (VBlank),
        .HBlank     (HBlank),
        .MODE       (MODE),
        .COLOR_SEL  (COLOR_SEL),
        .wRed       (wRed),
        .wGreen     (wGreen),
        .wBlue      (wBlue),
        .yes        (yes),
        .RED        (RED),
        .GREEN      (GREEN),
        .BLUE       (BLUE),
        .FrameCount (FrameCount)
    );

    // ---------------- model / scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    logic [11:0] pal_tab [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                                 12'hF00, 12'hF0F, 12'hFF0, 12'h777};

    int m_mode, m_color, m_fc, m_bx, m_by, m_dx, m_dy;
    bit m_prev_vb;
    bit rst_seen = 1'b0;

    function automatic void model_reset();
        m_mode = 0; m_color = 0; m_fc = 0;
        m_bx = 100; m_by = 100; m_dx = 0; m_dy = 0;
        m_prev_vb = 1'b0;
    endfunction

    function automatic void model_tick();
        m_fc    = (m_fc + 1) % 256;
        m_mode  = int'(MODE);
        m_color = int'(COLOR_SEL);
        if (m_dx == 0) begin
            if (m_bx + 4 + 64 > 800) begin m_bx = 736; m_dx = 1; end
            else m_bx = m_bx + 4;
        end else begin
            if (m_bx < 4) begin m_bx = 0; m_dx = 0; end
            else m_bx = m_bx - 4;
        end
        if (m_dy == 0) begin
            if (m_by + 4 + 64 > 600) begin m_by = 536; m_dy = 1; end
            else m_by = m_by + 4;
        end else begin
            if (m_by < 4) begin m_by = 0; m_dy = 0; end
            else m_by = m_by - 4;
        end
    endfunction

    function automatic logic [11:0] exp_pixel(input int x, input int y,
                                              input bit vb, input bit hb,
                                              input logic [3:0] wr, input logic [3:0] wg,
                                              input logic [3:0] wb, input bit ok);
        int p;
        if (vb || hb) return 12'h000;
        case (m_mode)
            1: begin p = x * y; return p[15:4]; end
            2: return ok ? {wr, wg, wb} : 12'h777;
            3: return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64)
                      ? pal_tab[(m_fc >> 5) & 7] : 12'h000;
            4: return pal_tab[((x + m_fc) >> 7) & 7];
            default: return (x < 100 || x >= 700 || y < 100 || y >= 500)
                            ? 12'hFFF : pal_tab[m_color];
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input int x, input int y, input bit vb, input bit hb,
                         input bit rst, input logic [3:0] wr, input logic [3:0] wg,
                         input logic [3:0] wb, input bit ok);
        logic [11:0] exp;
        @(negedge clk);
        if (rst_seen) begin
            n_checks++;
            if (FrameCount !== 8'(m_fc)) begin
                n_errors++;
                $display("FAIL frame_count: got %0d expected %0d", FrameCount, m_fc);
            end
        end
        if (exp_q.size() == 2) begin
            exp = exp_q.pop_front();
            n_checks++;
            if ({RED, GREEN, BLUE} !== exp) begin
                n_errors++;
                $display("FAIL pixel @%0t: got %h expected %h", $time, {RED, GREEN, BLUE}, exp);
            end
        end
        CurrentX = 11'(x); CurrentY = 11'(y);
        VBlank = vb; HBlank = hb; RESET = rst;
        wRed = wr; wGreen = wg; wBlue = wb; yes = ok;
        if (rst) begin
            // Everything still in flight is wiped by the reset edge.
            foreach (exp_q[i]) exp_q[i] = 12'h000;
            exp_q.push_back(12'h000);
            model_reset();
            rst_seen = 1'b1;
        end else begin
            exp_q.push_back(exp_pixel(x, y, vb, hb, wr, wg, wb, ok));
            if (vb && !m_prev_vb) model_tick();
            m_prev_vb = vb;
        end
    endtask

    task automatic pix(input int x, input int y);
        drive(x, y, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic tick();
        drive(0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        drive(0, 0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(400, 300, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(400, 300, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        n_checks++;
        if ({RED, GREEN, BLUE} !== 12'h000 || FrameCount !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state: got rgb=%h fc=%0d expected rgb=000 fc=0",
                     {RED, GREEN, BLUE}, FrameCount);
        end
        drive(0, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        // Before any tick: mode 0 with colour 0
        pix(400, 300);
        pix(50, 300);
    endtask

    task automatic test_mode0();
        MODE = 3'd0; COLOR_SEL = 3'd1;
        tick();
        pix(400, 300);   // 00F
        pix(50, 300);    // FFF
        pix(99, 100);
        pix(100, 100);
        pix(699, 499);
        pix(700, 300);
        pix(400, 500);
        pix(400, 99);
    endtask

    task automatic test_mode_sync();
        MODE = 3'd1;
        pix(400, 300);   // still mode 0
        pix(10, 300);
        tick();
        pix(3, 5);       // P = 15 -> 000
        pix(100, 200);   // P = 20000 -> 4E2
        pix(799, 599);
    endtask

    task automatic test_blank();
        for (int i = 0; i < 12; i++)
            drive($urandom_range(0, 799), $urandom_range(0, 599), 1'b0, 1'b1,
                  1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        // Blank drops here; the next two outputs must still be black.
        pix(400, 300);
        pix(401, 300);
        pix(402, 300);
        drive(403, 300, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        pix(404, 300);
    endtask

    task automatic test_overlay();
        MODE = 3'd2;
        tick();
        drive(400, 300, 1'b0, 1'b0, 1'b0, 4'hA, 4'hB, 4'hC, 1'b0);
        drive(400, 300, 1'b0, 1'b0, 1'b0, 4'hA, 4'hB, 4'hC, 1'b1);
        for (int i = 0; i < 8; i++)
            drive($urandom_range(0, 799), $urandom_range(0, 599), 1'b0, 1'b0, 1'b0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        // Reset in the middle of the line
        drive(410, 300, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 1'b1);
        drive(411, 300, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 4'h3, 1'b1);
        n_checks++;
        if ({RED, GREEN, BLUE} !== 12'h000 || FrameCount !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_midline: got rgb=%h fc=%0d expected rgb=000 fc=0",
                     {RED, GREEN, BLUE}, FrameCount);
        end
        pix(412, 300);
        pix(50, 50);
    endtask

    task automatic test_bars();
        do_reset();
        MODE = 3'd4;
        tick();          // FrameCount = 1
        pix(130, 300);   // (131>>7)=1 -> 00F
        for (int i = 0; i < 128; i++) tick();
        pix(130, 300);   // (259>>7)=2 -> 0F0
        for (int i = 0; i < 127; i++) begin
            tick();
            pix($urandom_range(0, 799), 300);
        end
        pix(130, 300);   // FrameCount back to 0 -> palette[1]
        pix(0, 300);
    endtask

    task automatic test_box();
        do_reset();
        MODE = 3'd3;
        for (int f = 0; f < 400; f++) begin
            tick();
            pix(m_bx, m_by);
            pix(m_bx + 63, m_by + 63);
            if (m_bx > 0) pix(m_bx - 1, m_by);
            if (m_by > 0) pix(m_bx, m_by - 1);
            if (m_bx + 64 < 800) pix(m_bx + 64, m_by);
            if (m_by + 64 < 600) pix(m_bx, m_by + 64);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            MODE = 3'($urandom_range(0, 7));
            COLOR_SEL = 3'($urandom_range(0, 7));
            tick();
            for (int i = 0; i < 16; i++)
                drive($urandom_range(0, 899), $urandom_range(0, 699), 1'b0,
                      ($urandom_range(0, 7) == 0), 1'b0,
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_reset();
        test_reset();
        test_mode0();
        test_mode_sync();
        test_blank();
        test_overlay();
        test_bars();
        test_box();
        test_random();
        drive(0, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
